// File: rtl/tx_prbs_scrambler.sv
// tx_prbs_scrambler: per-frame PRBS (1+x^14+x^15) byte scrambler feeding a 2-entry output buffer.
// Define FRAME_LEN_CHECK_EN to build frame-length policing (PAD/DROP states, err_short/err_long).

module tx_prbs_scrambler #(
  parameter logic [14:0] LFSR_SEED = 15'h00A9
`ifdef FRAME_LEN_CHECK_EN
`ifdef self_rs
  , parameter int unsigned RS_CNT = 232
`else
  , parameter int unsigned RS_CNT = 236
`endif
  , parameter int unsigned FRAME_LEN = RS_CNT + 3
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_input_tvalid,
  output logic        s_axis_input_tready,
  input  logic [7:0]  s_axis_input_tdata,
  input  logic        s_axis_input_tlast,
  output logic        m_axis_output_tvalid,
  input  logic        m_axis_output_tready,
  output logic [7:0]  m_axis_output_tdata,
  output logic        m_axis_output_tlast,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] frame_cnt
);

  // Eight LFSR steps; the first generated key bit lands in key[7].
  function automatic logic [22:0] prbs_byte(input logic [14:0] seed);
    logic [14:0] st;
    logic [7:0]  k;
    logic        fb;
    st = seed;
    k  = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      fb = st[13] ^ st[14];
      st = {st[13:0], fb};
      k  = {k[6:0], fb};
    end
    return {st, k};
  endfunction

  logic [14:0] lfsr, lfsr_adv, lfsr_nxt;
  logic [7:0]  key;
  logic        in_ready_r, in_hs;
  logic        push, push_last, pad_nxt;
  logic [7:0]  push_data;

  logic        out_valid, out_last, skid_valid, skid_last;
  logic [7:0]  out_data, skid_data;
  logic        out_valid_nxt, out_last_nxt, skid_valid_nxt, skid_last_nxt;
  logic [7:0]  out_data_nxt, skid_data_nxt;
  logic        out_free;

  assign {lfsr_adv, key} = prbs_byte(lfsr);
  assign in_hs           = s_axis_input_tvalid && in_ready_r;

`ifdef FRAME_LEN_CHECK_EN
  typedef enum logic [1:0] {IN_FRAME, PAD, DROP} state_t;

  localparam int unsigned      CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt;
  logic             err_short_r, err_long_r, short_nxt, long_nxt;

  always_comb begin
    push      = 1'b0;
    push_data = s_axis_input_tdata ^ key;
    push_last = 1'b0;
    lfsr_nxt  = lfsr;
    cnt_nxt   = byte_cnt;
    state_nxt = state;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      IN_FRAME: begin
        if (in_hs) begin
          push = 1'b1;
          if (byte_cnt == LAST_IDX) begin
            push_last = 1'b1;
            cnt_nxt   = '0;
            lfsr_nxt  = LFSR_SEED;
            if (!s_axis_input_tlast) begin
              long_nxt  = 1'b1;
              state_nxt = DROP;
            end
          end else begin
            cnt_nxt  = byte_cnt + CNT_ONE;
            lfsr_nxt = lfsr_adv;
            if (s_axis_input_tlast) begin
              short_nxt = 1'b1;
              state_nxt = PAD;
            end
          end
        end
      end
      PAD: begin
        // Pad bytes are scrambled zeros, i.e. the raw key stream.
        push_data = key;
        if (!skid_valid) begin
          push = 1'b1;
          if (byte_cnt == LAST_IDX) begin
            push_last = 1'b1;
            cnt_nxt   = '0;
            lfsr_nxt  = LFSR_SEED;
            state_nxt = IN_FRAME;
          end else begin
            cnt_nxt  = byte_cnt + CNT_ONE;
            lfsr_nxt = lfsr_adv;
          end
        end
      end
      DROP: begin
        if (in_hs && s_axis_input_tlast) state_nxt = IN_FRAME;
      end
      default: state_nxt = IN_FRAME;
    endcase
    pad_nxt = (state_nxt == PAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IN_FRAME;
      byte_cnt    <= '0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= cnt_nxt;
      err_short_r <= short_nxt;
      err_long_r  <= long_nxt;
    end
  end

  assign err_short = err_short_r;
  assign err_long  = err_long_r;
`else
  always_comb begin
    push      = in_hs;
    push_data = s_axis_input_tdata ^ key;
    push_last = s_axis_input_tlast;
    lfsr_nxt  = lfsr;
    if (in_hs) lfsr_nxt = s_axis_input_tlast ? LFSR_SEED : lfsr_adv;
  end

  assign pad_nxt   = 1'b0;
  assign err_short = 1'b0;
  assign err_long  = 1'b0;
`endif

  // A push only ever happens with the skid empty, so a draining skid never competes with it.
  assign out_free = !out_valid || m_axis_output_tready;

  always_comb begin
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_last_nxt   = out_last;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_last_nxt  = skid_last;
    if (out_free) begin
      if (skid_valid) begin
        out_valid_nxt  = 1'b1;
        out_data_nxt   = skid_data;
        out_last_nxt   = skid_last;
        skid_valid_nxt = 1'b0;
      end else begin
        out_valid_nxt = push;
        if (push) begin
          out_data_nxt = push_data;
          out_last_nxt = push_last;
        end
      end
    end else if (push) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = push_data;
      skid_last_nxt  = push_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= LFSR_SEED;
      in_ready_r <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      lfsr       <= lfsr_nxt;
      in_ready_r <= !skid_valid_nxt && !pad_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_last   <= out_last_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_last  <= skid_last_nxt;
      if (out_valid && m_axis_output_tready && out_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign s_axis_input_tready  = in_ready_r;
  assign m_axis_output_tvalid = out_valid;
  assign m_axis_output_tdata  = out_data;
  assign m_axis_output_tlast  = out_last;

endmodule
